// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Arbitrates the single register-file write port between the
//             pipeline write-back stage and a long-latency unit. Long-latency
//             results queue in a small in-order FIFO, drain in idle write-back
//             slots, and an age-based one-cycle pipeline stall forces a drain
//             when the FIFO head has waited too long.
//  Options  : define WB_ARB_BYPASS_EN to let an lu result reaching an idle,
//             empty arbiter be written in the same cycle (no enqueue).
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
  parameter int DEPTH    = 2,  // FIFO entries, power of two, >= 2
  parameter int MAX_WAIT = 4   // ungranted head cycles before a forced stall
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_valid,
  input  logic                       pipe_we,
  input  logic [4:0]                 pipe_rd,
  input  logic [31:0]                pipe_data,
  input  logic                       lu_valid,
  input  logic [4:0]                 lu_rd,
  input  logic [31:0]                lu_data,
  output logic                       lu_ready,
  output logic                       stall_pipe,
  output logic                       rf_we,
  output logic [4:0]                 rf_rd,
  output logic [31:0]                rf_data,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = ($clog2(MAX_WAIT + 1) < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [AW-1:0] C_AGE_LAST = AW'(MAX_WAIT - 1);

  // state
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [4:0]    rd_mem_d   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] age_q, age_d;
  logic          stall_q, stall_d;

  // per-cycle decisions
  logic pipe_req;
  logic fifo_empty;
  logic lu_accept;
  logic pop;
  logic bypass;
  logic push;

  assign fifo_count = count_q;
  assign stall_pipe = stall_q;
  assign fifo_empty = (count_q == '0);
  assign pipe_req   = pipe_valid & pipe_we & (pipe_rd != 5'd0);
  assign lu_ready   = !rst & (count_q < C_DEPTH);
  assign lu_accept  = lu_valid & lu_ready;

  // Write-port grant: stall drain, then pipe, then FIFO head, then bypass
  always_comb begin
    rf_we   = 1'b0;
    rf_rd   = 5'd0;
    rf_data = 32'd0;
    pop     = 1'b0;
    bypass  = 1'b0;
    if (rst) begin
      rf_we = 1'b0;
    end else if (stall_q) begin
      // a stall is only ever scheduled with a non-empty FIFO
      rf_we   = 1'b1;
      rf_rd   = rd_mem_q[rd_ptr_q];
      rf_data = data_mem_q[rd_ptr_q];
      pop     = 1'b1;
    end else if (pipe_req) begin
      rf_we   = 1'b1;
      rf_rd   = pipe_rd;
      rf_data = pipe_data;
    end else if (!fifo_empty) begin
      rf_we   = 1'b1;
      rf_rd   = rd_mem_q[rd_ptr_q];
      rf_data = data_mem_q[rd_ptr_q];
      pop     = 1'b1;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (lu_accept && (lu_rd != 5'd0)) begin
      rf_we   = 1'b1;
      rf_rd   = lu_rd;
      rf_data = lu_data;
      bypass  = 1'b1;
    end
`endif
  end

  // x0 results are accepted and dropped; bypassed results skip the FIFO
  assign push = lu_accept & (lu_rd != 5'd0) & !bypass;

  // FIFO storage, pointers and occupancy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_mem_d[i]   = rd_mem_q[i];
      data_mem_d[i] = data_mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = lu_rd;
      data_mem_d[wr_ptr_q] = lu_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Head age and forced-stall scheduling; a pop always clears both
  always_comb begin
    if (fifo_empty || pop) begin
      age_d = '0;
    end else begin
      age_d = age_q + 1'b1;
    end
    stall_d = (count_d != '0) && !pop && (age_q == C_AGE_LAST);
  end

  // Storage flops carry no reset: contents are only read below count_q
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_mem_q[i]   <= rd_mem_d[i];
      data_mem_q[i] <= data_mem_d[i];
    end
  end

  // Control flops with synchronous reset discarding buffered results
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
    end
  end

endmodule
`default_nettype wire
